serial_adder: RTL

//  Bit-serial WIDTH-bit adder: a + b + cin, one bit per clock, LSB first.

---
 rtl/adder_pkg.sv | 21 ++
 rtl/full_adder.sv | 20 ++
 rtl/serial_adder.sv | 106 ++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and width limits.
package adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

  // Bit counter needs at least one bit even when WIDTH is 1.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// 1-bit full adder built from two half adders with the carries ORed together.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0;
  logic c0;
  logic c1;

  assign s0 = a ^ b;
  assign c0 = a & b;
  assign s  = s0 ^ ci;
  assign c1 = s0 & ci;
  assign co = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder (a + b + cin), LSB first, one bit per clock,
// with valid/ready handshakes on both the operand and result sides.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;
  logic [WIDTH-1:0] sum_nxt;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_co;

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Shift expressions written so WIDTH=1 needs no zero-width slices.
  always_comb begin
    a_nxt            = a_sh >> 1;
    b_nxt            = b_sh >> 1;
    sum_nxt          = sum_sh >> 1;
    sum_nxt[WIDTH-1] = fa_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      carry     <= 1'b0;
      cnt       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            carry    <= cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh   <= a_nxt;
          b_sh   <= b_nxt;
          sum_sh <= sum_nxt;
          carry  <= fa_co;
          cnt    <= cnt + 1'b1;
          // Result is published only on the last bit, so sum/cout hold the previous answer throughout RUN.
          if (cnt == CNT_LAST) begin
            sum       <= sum_nxt;
            cout      <= fa_co;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
